ysyx_23060203_axi_rd_arbiter: RTL and testbench
===============================================

// Module: ysyx_23060203_axi_rd_arbiter
// PURPOSE
//  Two-master AXI4 read-channel arbiter sharing one downstream read port between the IFU (m0) and the EXU/LSU (m1).
//  Sits between the fetch/execute units and the crossbar/xbar to memory and MMIO; write channels bypass this block.
//  One transaction outstanding at a time; the grant is held from AR acceptance until the final R beat (rlast).
// PARAMETERS
//  LSU_FIRST  1   1: m1 wins simultaneous requests when the fairness bit is clear; 0: m0 wins.
//  RR_EN      1   1: round-robin (last winner loses next tie); 0: fixed priority per LSU_FIRST.
//  ADDR_W     32  address width.  DATA_W 64  R data width.
// PORTS
//  clock               in   1        system clock, all state on posedge
//  reset               in   1        asynchronous, active-low (0 = reset)
//  m{0,1}_arvalid      in   1        master read address valid
//  m{0,1}_arready      out  1        address accepted (only when granted and s_arready)
//  m{0,1}_araddr       in   ADDR_W   read address
//  m{0,1}_arid/arlen   in   4/8      AXI id / burst length-1
//  m{0,1}_arsize/burst in   3/2      AXI size / burst type
//  m{0,1}_rvalid       out  1        read data valid (granted master only)
//  m{0,1}_rready       in   1        master accepts data
//  m{0,1}_rdata        out  DATA_W   read data (s_rdata broadcast, qualified by rvalid)
//  m{0,1}_rresp/rlast  out  2/1      response / last beat
//  s_arvalid/arready   out/in 1/1    downstream address handshake
//  s_araddr..arburst   out  as above muxed from granted master
//  s_rvalid/rready     in/out 1/1    downstream data handshake
//  s_rdata/rresp/rlast in   DATA_W/2/1
//  busy                out  1        1 when state != IDLE (for perf counters / fence.i drain)
// BEHAVIOUR
//  - States: IDLE, ADDR, DATA. Registers: state, gnt (0=m0,1=m1), last_win.
//  - Reset (reset=0, async): state=IDLE, gnt=0, last_win=0; all out valids/readies 0, busy=0.
//  - IDLE: if any m*_arvalid, latch winner into gnt, go ADDR next cycle. No combinational IDLE->slave path:
//    s_arvalid rises exactly 1 cycle after first m*_arvalid.
//  - Tie rule: RR_EN=1 -> winner = ~last_win; RR_EN=0 -> winner = LSU_FIRST. Single requester always wins.
//  - ADDR: s_arvalid = m[gnt]_arvalid; s_ar* = m[gnt]_ar*; m[gnt]_arready = s_arready; other master arready=0.
//    On s_arvalid&s_arready -> DATA, last_win<=gnt. If granted master drops arvalid (protocol error) stay ADDR.
//  - DATA: m[gnt]_rvalid = s_rvalid; s_rready = m[gnt]_rready; rdata/rresp/rlast forwarded combinationally.
//    On s_rvalid&s_rready&s_rlast -> IDLE. Non-last beats stay DATA. Other master rvalid=0 always.
//  - Grant never changes outside IDLE; the losing master's arvalid stays pending, is served after IDLE.
//  - Back-to-back: minimum 1 IDLE cycle between transactions (arbitration cycle); throughput 1 txn / (3+len) cycles best.
//  - s_rready and s_arvalid are 0 in IDLE; any s_rvalid in IDLE/ADDR is ignored (not forwarded).
//  - rresp errors forwarded unmodified; no timeout, no ID remapping (arid passed through).
//  - reset asserted mid-transaction: immediate IDLE; downstream must also be reset (shared reset domain).
// TESTING
//  1 Reset: hold reset=0 with m0/m1 arvalid=1 -> s_arvalid=0, busy=0, m*_arready=0.
//  2 m1 only, araddr=0x8000_0010 arsize=2, s_arready same cycle, rdata=0x1122 rlast=1 after 2 cyc ->
//    s_arvalid at cycle 1, m1_rvalid with 0x1122, m0_rvalid=0, IDLE after beat.
//  3 Simultaneous m0/m1 arvalid, RR_EN=1 LSU_FIRST=1 after reset -> order m1,m0,m1,m0 over 4 txns.
//  4 RR_EN=0 LSU_FIRST=0, m0 requests continuously, m1 waiting -> m0 wins every tie (m1 starved; documented).
//  5 m0 burst arlen=3 with s_rvalid gaps and m0_rready stalls -> 4 beats in order, DATA held until rlast handshake;
//    m1 arvalid raised mid-burst gets arready only after return to IDLE+1.
//  6 s_arready held 0 for 10 cycles -> s_ar* stable, grant unchanged; async reset pulse mid-DATA -> IDLE next edge-free.

Source files
------------

// File: rtl/ysyx_23060203_axi_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter: IFU (m0) and LSU (m1) share one downstream read port.
// One transaction in flight; the grant is held from AR acceptance until the rlast beat.
module ysyx_23060203_axi_rd_arbiter #(
  parameter bit          LSU_FIRST = 1'b1,
  parameter bit          RR_EN     = 1'b1,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64
) (
  input  logic              clock,
  input  logic              reset,
  // master 0 (IFU)
  input  logic              m0_arvalid,
  output logic              m0_arready,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [3:0]        m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  // master 1 (LSU)
  input  logic              m1_arvalid,
  output logic              m1_arready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [3:0]        m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  // downstream slave port
  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [3:0]        s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAddr = 2'd1,
    StData = 2'd2
  } state_e;

  state_e state_q;
  logic   gnt_q;
  logic   last_win_q;
  logic   busy_q;
  logic   winner;
  logic   ar_hs;
  logic   r_done;

  // A lone requester always wins; ties go to the fairness bit or the fixed preference.
  always_comb begin
    winner = m1_arvalid;
    if (m0_arvalid && m1_arvalid) begin
      winner = RR_EN ? ~last_win_q : LSU_FIRST;
    end
  end

  assign ar_hs  = s_arvalid & s_arready;
  assign r_done = s_rvalid & s_rready & s_rlast;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      gnt_q      <= 1'b0;
      last_win_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (m0_arvalid || m1_arvalid) begin
            gnt_q   <= winner;
            state_q <= StAddr;
            busy_q  <= 1'b1;
          end
        end
        StAddr: begin
          // A granted master that drops arvalid keeps the grant until it re-asserts.
          if (ar_hs) begin
            state_q    <= StData;
            last_win_q <= gnt_q;
          end
        end
        StData: begin
          if (r_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // Address fields follow the grant; only s_arvalid is qualified by state.
  always_comb begin
    s_araddr  = gnt_q ? m1_araddr  : m0_araddr;
    s_arid    = gnt_q ? m1_arid    : m0_arid;
    s_arlen   = gnt_q ? m1_arlen   : m0_arlen;
    s_arsize  = gnt_q ? m1_arsize  : m0_arsize;
    s_arburst = gnt_q ? m1_arburst : m0_arburst;
  end

  always_comb begin
    s_arvalid  = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    s_rready   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    if (state_q == StAddr) begin
      s_arvalid  = gnt_q ? m1_arvalid : m0_arvalid;
      m0_arready = ~gnt_q & s_arready;
      m1_arready = gnt_q & s_arready;
    end
    if (state_q == StData) begin
      s_rready  = gnt_q ? m1_rready : m0_rready;
      m0_rvalid = ~gnt_q & s_rvalid;
      m1_rvalid = gnt_q & s_rvalid;
    end
  end

  // Data payload is broadcast; rvalid alone tells each master whether it is theirs.
  assign m0_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m0_rlast = s_rlast;
  assign m1_rdata = s_rdata;
  assign m1_rresp = s_rresp;
  assign m1_rlast = s_rlast;

endmodule

// File: tb/tb_ysyx_23060203_axi_rd_arbiter.sv
// Randomized bench for the two-master read arbiter: bench-side masters and slave,
// a transaction-level reference model, and a per-cycle compare process.
module tb_ysyx_23060203_axi_rd_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b1;

  logic        arv   [2] = '{1'b0, 1'b0};
  logic [31:0] addr  [2] = '{32'h0, 32'h0};
  logic [3:0]  id    [2] = '{4'h0, 4'h0};
  logic [7:0]  len   [2] = '{8'h0, 8'h0};
  logic [2:0]  size  [2] = '{3'h0, 3'h0};
  logic [1:0]  burst [2] = '{2'h0, 2'h0};
  logic        rr    [2] = '{1'b0, 1'b0};

  logic        m_arready [2];
  logic        m_rvalid  [2];
  logic [63:0] m_rdata   [2];
  logic [1:0]  m_rresp   [2];
  logic        m_rlast   [2];

  logic        s_arvalid, s_rready, busy;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_arready = 1'b0;
  logic        s_rvalid  = 1'b0;
  logic [63:0] s_rdata   = 64'h0;
  logic [1:0]  s_rresp   = 2'h0;
  logic        s_rlast   = 1'b0;

  // fixed-priority instance, every tie input held asserted
  logic        f_arready [2];
  logic        f_rvalid  [2];
  logic [63:0] f_rdata   [2];
  logic [1:0]  f_rresp   [2];
  logic        f_rlast   [2];
  logic        f_sarvalid, f_srready, f_busy;
  logic [31:0] f_araddr;
  logic [3:0]  f_arid;
  logic [7:0]  f_arlen;
  logic [2:0]  f_arsize;
  logic [1:0]  f_arburst;

  int n_pass = 0;
  int n_total = 0;

  // reference model state: phase 0 idle, 1 address, 2 data
  int ph = 0;
  int own = 0;
  int lastw = 0;
  bit ar_fire [2] = '{1'b0, 1'b0};
  bit s_ar_fire = 1'b0;
  bit r_fire = 1'b0;

  // stimulus knobs
  bit auto_req [2] = '{1'b0, 1'b0};
  int req_rate = 0;
  int rready_rate [2] = '{100, 100};
  int arready_rate = 100;
  int rvalid_rate = 100;
  int junk_rate = 0;
  bit use_force = 1'b0;
  logic [63:0] force_data = 64'h0;
  int beats = 0;
  bit r_hold = 1'b0;

  int dut_order [$];
  int m0_beats = 0;
  int f_cnt [2] = '{0, 0};

  ysyx_23060203_axi_rd_arbiter u_dut (
    .clock(clock), .reset(reset),
    .m0_arvalid(arv[0]), .m0_arready(m_arready[0]), .m0_araddr(addr[0]), .m0_arid(id[0]),
    .m0_arlen(len[0]), .m0_arsize(size[0]), .m0_arburst(burst[0]), .m0_rvalid(m_rvalid[0]),
    .m0_rready(rr[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]),
    .m1_arvalid(arv[1]), .m1_arready(m_arready[1]), .m1_araddr(addr[1]), .m1_arid(id[1]),
    .m1_arlen(len[1]), .m1_arsize(size[1]), .m1_arburst(burst[1]), .m1_rvalid(m_rvalid[1]),
    .m1_rready(rr[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .busy(busy)
  );

  ysyx_23060203_axi_rd_arbiter #(.LSU_FIRST(1'b0), .RR_EN(1'b0)) u_fix (
    .clock(clock), .reset(reset),
    .m0_arvalid(1'b1), .m0_arready(f_arready[0]), .m0_araddr(32'h100), .m0_arid(4'h0),
    .m0_arlen(8'h0), .m0_arsize(3'h2), .m0_arburst(2'h1), .m0_rvalid(f_rvalid[0]),
    .m0_rready(1'b1), .m0_rdata(f_rdata[0]), .m0_rresp(f_rresp[0]), .m0_rlast(f_rlast[0]),
    .m1_arvalid(1'b1), .m1_arready(f_arready[1]), .m1_araddr(32'h200), .m1_arid(4'h1),
    .m1_arlen(8'h0), .m1_arsize(3'h2), .m1_arburst(2'h1), .m1_rvalid(f_rvalid[1]),
    .m1_rready(1'b1), .m1_rdata(f_rdata[1]), .m1_rresp(f_rresp[1]), .m1_rlast(f_rlast[1]),
    .s_arvalid(f_sarvalid), .s_arready(1'b1), .s_araddr(f_araddr), .s_arid(f_arid),
    .s_arlen(f_arlen), .s_arsize(f_arsize), .s_arburst(f_arburst), .s_rvalid(1'b1),
    .s_rready(f_srready), .s_rdata(64'h0), .s_rresp(2'h0), .s_rlast(1'b1), .busy(f_busy)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic new_req(input int i);
    arv[i]   = 1'b1;
    addr[i]  = $urandom;
    id[i]    = 4'($urandom);
    len[i]   = 8'($urandom_range(0, 3));
    size[i]  = 3'($urandom_range(0, 3));
    burst[i] = 2'($urandom_range(0, 2));
  endtask

  // Reference model: one transaction at a time, grant fixed until the rlast handshake.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ph <= 0; own <= 0; lastw <= 0;
    end else if (ph == 0) begin
      if (arv[0] || arv[1]) begin
        own <= (arv[0] && arv[1]) ? 1 - lastw : (arv[1] ? 1 : 0);
        ph  <= 1;
      end
    end else if (ph == 1) begin
      if (s_ar_fire) begin ph <= 2; lastw <= own; end
    end else begin
      if (r_fire && s_rlast) ph <= 0;
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    bit e_sarv, e_srr;
    bit e_arr [2];
    bit e_rv [2];
    @(negedge clock);
    e_sarv = (ph == 1) && arv[own];
    e_srr  = (ph == 2) && rr[own];
    for (int i = 0; i < 2; i++) begin
      e_arr[i] = (ph == 1) && (own == i) && s_arready;
      e_rv[i]  = (ph == 2) && (own == i) && s_rvalid;
    end
    chk("busy", busy, (ph != 0));
    chk("s_arvalid", s_arvalid, e_sarv);
    chk("s_rready", s_rready, e_srr);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_arready", i), m_arready[i], e_arr[i]);
      chk($sformatf("m%0d_rvalid", i), m_rvalid[i], e_rv[i]);
      if (e_rv[i])
        chk($sformatf("m%0d_rbeat", i), {m_rdata[i][60:0], m_rresp[i], m_rlast[i]},
            {s_rdata[60:0], s_rresp, s_rlast});
    end
    if (e_sarv)
      chk("s_ar_fields", {s_araddr, s_arid, s_arlen, s_arsize, s_arburst},
          {addr[own], id[own], len[own], size[own], burst[own]});
    for (int i = 0; i < 2; i++) ar_fire[i] = e_arr[i] && arv[i];
    s_ar_fire = e_sarv && s_arready;
    r_fire    = (ph == 2) && s_rvalid && rr[own];
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        if (m_arready[i] && arv[i]) dut_order.push_back(i);
        f_cnt[i] += int'(f_arready[i]);
      end
      if (m_rvalid[0] && rr[0]) m0_beats++;
    end
  end

  // Bench-side masters and slave.
  initial forever begin
    @(posedge clock);
    #1;
    if (!reset) begin
      beats = 0; r_hold = 1'b0; s_rvalid = 1'b0; s_arready = 1'b0;
    end else begin
      if (s_ar_fire) begin beats = int'(len[own]) + 1; r_hold = 1'b0; end
      if (r_fire) begin beats--; r_hold = 1'b0; end
      if (beats > 0) begin
        if (!r_hold && $urandom_range(0, 99) < rvalid_rate) begin
          r_hold  = 1'b1;
          s_rdata = use_force ? force_data : {$urandom, $urandom};
          s_rresp = 2'($urandom);
          s_rlast = (beats == 1);
        end
        s_rvalid = r_hold;
      end else begin
        // stray beats outside a data phase must never reach a master
        s_rvalid = $urandom_range(0, 99) < junk_rate;
        s_rdata  = {$urandom, $urandom};
        s_rresp  = 2'($urandom);
        s_rlast  = 1'($urandom);
      end
      s_arready = $urandom_range(0, 99) < arready_rate;
      for (int i = 0; i < 2; i++) begin
        if (ar_fire[i]) arv[i] = 1'b0;
        if (!arv[i] && auto_req[i] && $urandom_range(0, 99) < req_rate) new_req(i);
        rr[i] = $urandom_range(0, 99) < rready_rate[i];
      end
    end
  end

  task automatic pulse_reset();
    @(posedge clock); #3 reset = 1'b0;
    @(posedge clock); #3 reset = 1'b1;
  endtask

  task automatic wait_quiet(input string name);
    int k;
    k = 0;
    while (k < 400 && (ph != 0 || arv[0] || arv[1] || beats != 0)) begin
      @(negedge clock); k++;
    end
    if (k >= 400) chk({name, "_quiet_timeout"}, 0, 1);
  endtask

  initial begin
    int k;
    int exp_ord [4] = '{1, 0, 1, 0};
    // reset held with both masters requesting
    #1 reset = 1'b0;
    arv[0] = 1'b1; arv[1] = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m0_arready", m_arready[0], 0);
    chk("rst_m1_arready", m_arready[1], 0);
    arv[0] = 1'b0; arv[1] = 1'b0;
    reset = 1'b1;

    // m1 alone, single beat
    use_force = 1'b1; force_data = 64'h1122; junk_rate = 0;
    @(posedge clock); #2;
    arv[1] = 1'b1; addr[1] = 32'h8000_0010; size[1] = 3'd2; len[1] = 8'd0;
    id[1] = 4'd3; burst[1] = 2'd1;
    @(negedge clock);
    chk("t2_c0_s_arvalid", s_arvalid, 0);
    @(negedge clock);
    chk("t2_c1_s_arvalid", s_arvalid, 1);
    chk("t2_c1_s_araddr", s_araddr, 32'h8000_0010);
    @(negedge clock);
    chk("t2_c2_m1_rvalid", m_rvalid[1], 1);
    chk("t2_c2_m1_rdata", m_rdata[1], 64'h1122);
    chk("t2_c2_m1_rlast", m_rlast[1], 1);
    chk("t2_c2_m0_rvalid", m_rvalid[0], 0);
    @(negedge clock);
    chk("t2_c3_busy", busy, 0);
    use_force = 1'b0;

    // simultaneous continuous requests after reset: round-robin from m1
    pulse_reset();
    dut_order.delete();
    auto_req[0] = 1'b1; auto_req[1] = 1'b1; req_rate = 100;
    k = 0;
    while (k < 200 && dut_order.size() < 4) begin @(negedge clock); k++; end
    if (dut_order.size() < 4) chk("t3_order_timeout", dut_order.size(), 4);
    else for (int i = 0; i < 4; i++) chk($sformatf("t3_order%0d", i), dut_order[i], exp_ord[i]);
    auto_req[0] = 1'b0; auto_req[1] = 1'b0;
    wait_quiet("t3");

    // m0 4-beat burst with gaps and stalls; m1 arrives mid-burst
    rvalid_rate = 50; rready_rate[0] = 60; junk_rate = 30; arready_rate = 70;
    @(posedge clock); #2;
    m0_beats = 0;
    arv[0] = 1'b1; addr[0] = 32'h3000_0040; len[0] = 8'd3; size[0] = 3'd3;
    id[0] = 4'd5; burst[0] = 2'd1;
    k = 0;
    while (k < 100 && ph != 2) begin @(negedge clock); k++; end
    @(posedge clock); #2;
    arv[1] = 1'b1; addr[1] = 32'h1000_0000; len[1] = 8'd0; size[1] = 3'd2;
    id[1] = 4'd9; burst[1] = 2'd0;
    k = 0;
    while (k < 300 && m0_beats < 4) begin @(negedge clock); k++; end
    chk("t5_m0_beats", m0_beats, 4);
    wait_quiet("t5");
    chk("t5_m0_beats_final", m0_beats, 4);

    // randomized traffic
    auto_req[0] = 1'b1; auto_req[1] = 1'b1;
    for (int blk = 0; blk < 10; blk++) begin
      req_rate = $urandom_range(10, 100);
      arready_rate = $urandom_range(20, 100);
      rvalid_rate = $urandom_range(20, 100);
      rready_rate[0] = $urandom_range(20, 100);
      rready_rate[1] = $urandom_range(20, 100);
      junk_rate = $urandom_range(0, 50);
      repeat (200) @(posedge clock);
    end
    auto_req[0] = 1'b0; auto_req[1] = 1'b0;
    arready_rate = 100; rvalid_rate = 100; rready_rate[0] = 100; rready_rate[1] = 100;
    wait_quiet("rand");

    // slave stalls AR for 10 cycles, then reset lands mid-data
    arready_rate = 0; rvalid_rate = 0; junk_rate = 0;
    @(posedge clock); #2;
    arv[0] = 1'b1; addr[0] = 32'hA5A5_0008; len[0] = 8'd3; size[0] = 3'd3;
    id[0] = 4'd7; burst[0] = 2'd1;
    @(negedge clock);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      chk("t6_s_araddr", s_araddr, 32'hA5A5_0008);
      chk("t6_m0_arready", m_arready[0], 0);
      chk("t6_busy", busy, 1);
    end
    arready_rate = 100;
    k = 0;
    while (k < 50 && ph != 2) begin @(negedge clock); k++; end
    chk("t6_in_data", ph, 2);
    @(posedge clock); #3 reset = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_s_rready", s_rready, 0);
    chk("t6_rst_s_arvalid", s_arvalid, 0);
    @(posedge clock); #3 reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("t6_after_busy", busy, 0);

    chk("fix_m1_starved", f_cnt[1], 0);
    chk("fix_m0_served", (f_cnt[0] > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
